// File: rtl/calc_port_req_issuer_if.sv
// Host-side command channel plus the DUT request/response channel of one calculator port.
interface calc_port_req_issuer_if;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_cmd;
   logic [3:0]  in_d1;
   logic [3:0]  in_d2;
   logic [3:0]  in_r1;
   logic [31:0] in_data;

   logic [3:0]  req_cmd;
   logic [3:0]  req_d1;
   logic [3:0]  req_d2;
   logic [3:0]  req_r1;
   logic [1:0]  req_tag;
   logic [31:0] req_data;

   logic [1:0]  out_resp;
   logic [1:0]  out_tag;
   logic [31:0] out_data;

   logic        rsp_valid;
   logic [1:0]  rsp_code;
   logic [1:0]  rsp_tag;
   logic [31:0] rsp_data;
   logic        rsp_timeout;
   logic        err_spurious;
   logic        busy;

   modport master (
      input  in_valid, in_cmd, in_d1, in_d2, in_r1, in_data,
      input  out_resp, out_tag, out_data,
      output in_ready,
      output req_cmd, req_d1, req_d2, req_r1, req_tag, req_data,
      output rsp_valid, rsp_code, rsp_tag, rsp_data, rsp_timeout,
      output err_spurious, busy
   );

   modport slave (
      output in_valid, in_cmd, in_d1, in_d2, in_r1, in_data,
      output out_resp, out_tag, out_data,
      input  in_ready,
      input  req_cmd, req_d1, req_d2, req_r1, req_tag, req_data,
      input  rsp_valid, rsp_code, rsp_tag, rsp_data, rsp_timeout,
      input  err_spurious, busy
   );
endinterface

// File: rtl/calc_port_req_issuer.sv
// Per-port request issuer: buffers host commands, allocates one of four tags per request,
// spaces requests by one idle cycle, and retires responses or timed-out tags.
module calc_port_req_issuer #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 64
) (
   input logic                    clk,
   input logic                    reset,
   calc_port_req_issuer_if.master bus
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, GAP, WAIT_TAG} state_t;

   typedef struct packed {
      logic [3:0]  cmd;
      logic [3:0]  d1;
      logic [3:0]  d2;
      logic [3:0]  r1;
      logic [31:0] data;
   } entry_t;

   state_t        state, state_next;
   entry_t        fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic [3:0]    tag_busy;
   logic [TW-1:0] timer [4];

   logic       push, issue, fifo_nonempty, any_free, resp_hit, spurious, exp_any;
   logic [1:0] alloc_tag, exp_tag;
   logic [3:0] expired;

   entry_t      req_q;
   logic [1:0]  req_tag_q;
   logic        rsp_valid_q, rsp_timeout_q, err_q;
   logic [1:0]  rsp_code_q, rsp_tag_q;
   logic [31:0] rsp_data_q;

   assign bus.in_ready  = (count != CW'(FIFO_DEPTH));
   assign push          = bus.in_valid && bus.in_ready;
   assign fifo_nonempty = (count != '0);
   assign resp_hit      = (bus.out_resp != 2'b00) && tag_busy[bus.out_tag];
   assign spurious      = (bus.out_resp != 2'b00) && !tag_busy[bus.out_tag];

   // A timer at 1 marks the expiry cycle; 0 means a timeout deferred by a same-cycle response.
   always_comb begin
      alloc_tag = '0;
      any_free  = 1'b0;
      exp_tag   = '0;
      exp_any   = 1'b0;
      expired   = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         expired[i] = tag_busy[i] && (timer[i] <= TW'(1));
         if (!tag_busy[i] && !any_free) begin
            alloc_tag = 2'(i);
            any_free  = 1'b1;
         end
         if (expired[i] && !exp_any) begin
            exp_tag = 2'(i);
            exp_any = 1'b1;
         end
      end
   end

   // GAP takes the IDLE decision itself so back-to-back requests sustain one per two cycles.
   always_comb begin
      state_next = state;
      case (state)
         ISSUE:   state_next = GAP;
         default: begin
            if (!fifo_nonempty)
               state_next = IDLE;
            else if (any_free)
               state_next = ISSUE;
            else
               state_next = WAIT_TAG;
         end
      endcase
   end

   assign issue = (state_next == ISSUE);

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= '{bus.in_cmd, bus.in_d1, bus.in_d2, bus.in_r1, bus.in_data};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         count         <= '0;
         tag_busy      <= '0;
         req_q         <= '0;
         req_tag_q     <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_timeout_q <= 1'b0;
         rsp_code_q    <= '0;
         rsp_tag_q     <= '0;
         rsp_data_q    <= '0;
         err_q         <= 1'b0;
         for (int unsigned i = 0; i < 4; i++)
            timer[i] <= '0;
      end else begin
         state <= state_next;
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (issue)
            rd_ptr <= rd_ptr + AW'(1);
         count     <= count + CW'(push) - CW'(issue);
         req_q     <= issue ? fifo_mem[rd_ptr] : '0;
         req_tag_q <= issue ? alloc_tag : '0;

         rsp_valid_q   <= resp_hit || exp_any;
         rsp_timeout_q <= !resp_hit && exp_any;
         rsp_tag_q     <= resp_hit ? bus.out_tag : (exp_any ? exp_tag : '0);
         rsp_code_q    <= resp_hit ? bus.out_resp : '0;
         rsp_data_q    <= resp_hit ? bus.out_data : '0;
         err_q         <= err_q || spurious;

         for (int unsigned i = 0; i < 4; i++) begin
            if (issue && alloc_tag == 2'(i)) begin
               tag_busy[i] <= 1'b1;
               timer[i]    <= TW'(TIMEOUT);
            end else if ((resp_hit && bus.out_tag == 2'(i)) ||
                         (!resp_hit && exp_any && exp_tag == 2'(i))) begin
               tag_busy[i] <= 1'b0;
               timer[i]    <= '0;
            end else if (tag_busy[i] && timer[i] != '0) begin
               timer[i] <= timer[i] - TW'(1);
            end
         end
      end
   end

   assign bus.req_cmd      = req_q.cmd;
   assign bus.req_d1       = req_q.d1;
   assign bus.req_d2       = req_q.d2;
   assign bus.req_r1       = req_q.r1;
   assign bus.req_data     = req_q.data;
   assign bus.req_tag      = req_tag_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_timeout  = rsp_timeout_q;
   assign bus.rsp_code     = rsp_code_q;
   assign bus.rsp_tag      = rsp_tag_q;
   assign bus.rsp_data     = rsp_data_q;
   assign bus.err_spurious = err_q;
   assign bus.busy         = (count != '0) || (tag_busy != '0);
endmodule
